// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, the IDLE/BREAK state constants
// and the idle line level, reusable by both receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

    localparam uart_state_t UART_IDLE_STATE  = ST_IDLE;
    localparam uart_state_t UART_BREAK_STATE = ST_BREAK;
    localparam logic        LINE_IDLE        = 1'b1;

    // True when data bits plus the received parity bit disagree with the chosen sense.
    function automatic logic parity_mismatch(input logic data_xor, input logic par_bit,
                                             input logic odd);
        return (data_xor ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// reset to RESET_VAL so a quiet line does not look like an edge after reset.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver, LSB first, mid-bit sampling, break detection.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects its sense).
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_r,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy,
    output uart_state_t          state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 line;
    logic                 line_q;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                 par_lat;
`endif

    uart_sync #(.RESET_VAL(LINE_IDLE)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (data_r),
        .q   (line)
    );

    assign busy = (state != UART_IDLE_STATE);

`ifndef UART_RX_PARITY_EN
    assign parity_err = PARITY_ODD & 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            line_q     <= LINE_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_lat    <= 1'b0;
`endif
        end else begin
            line_q     <= line;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (line_q && !line) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!line) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            par_lat <= 1'b0;
`endif
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // Counter was cleared at the start-bit middle, so a full period lands mid-bit.
                ST_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        shreg   <= {line, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        par_lat <= parity_mismatch(^shreg, line, PARITY_ODD);
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (line) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_lat;
`endif
                            state      <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= UART_BREAK_STATE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // Only a high line releases BREAK, so a held-low line yields one error.
                ST_BREAK: begin
                    if (line) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, legal 5..9: number of data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, legal 4..65535: clk cycles per bit period.
REQ-003 SHALL have parameter PARITY_ODD, default 0: 0 means even parity, 1 means odd; used only when parity is compiled in.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port data_r, input, 1: asynchronous serial line, idle high.
REQ-007 SHALL have port data_out, output, DATA_BITS: last received word.
REQ-008 SHALL have port data_valid, output, 1: one-cycle pulse, data_out updated.
REQ-009 SHALL have port frame_err, output, 1: one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port parity_err, output, 1: one-cycle pulse, parity mismatch; tied 0 when parity is compiled out.
REQ-011 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-012 SHALL pass data_r through a 2-flop synchronizer (preset high) before any use; all latencies below are from the synchronized line.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-014 IDLE: a synchronized high-to-low edge SHALL enter START and clear the bit-period counter.
REQ-015 START: at count CLKS_PER_BIT/2-1 (start-bit middle), line low SHALL enter DATA with the counter cleared; line high SHALL return to IDLE as a glitch, with no flags raised.
REQ-016 DATA: each bit SHALL be sampled when the counter reaches CLKS_PER_BIT-1, i.e. at bit middle.
REQ-017 DATA: bits SHALL be shifted LSB first; after DATA_BITS samples, go to PARITY if compiled in, else STOP.
REQ-018 PARITY: the bit SHALL be sampled at mid-bit; mismatch SHALL be latched internally, and the state SHALL advance to STOP.
REQ-019 STOP: at mid-bit, line high SHALL load data_out, pulse data_valid, pulse parity_err if latched, and return to IDLE.
REQ-020 STOP: at mid-bit, line low SHALL pulse frame_err, leave data_out unchanged, assert no data_valid, and enter BREAK.
REQ-021 BREAK: SHALL remain until the synchronized line is high, then go to IDLE; a line held low SHALL NOT produce repeat frames.
REQ-022 The counter SHALL be $clog2(CLKS_PER_BIT) bits wide, reset to 0 at every bit boundary, and never wrap mid-bit.
REQ-023 data_out SHALL hold its value between frames; parity_err and data_valid SHALL pulse on the same cycle.
REQ-024 A new start edge SHALL be accepted on the cycle after returning to IDLE, so back-to-back frames need no extra idle time.

Reset
REQ-025 rst low SHALL asynchronously force IDLE, counter 0, shift register 0, data_out 0, synchronizer 1s, and all pulse outputs and busy to 0.
REQ-026 Reset deasserted mid-frame SHALL restart in IDLE and discard the partial frame without flags.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined SHALL add the PARITY state and parity_err logic; frame length is 1+DATA_BITS+1+1 bits.
REQ-028 Macro UART_RX_PARITY_EN undefined SHALL remove the PARITY state entirely and tie parity_err to 0; frame length is 1+DATA_BITS+1 bits.

Structure
REQ-029 State encoding (3-bit enum) and the BREAK/IDLE constants SHALL live in shared package uart_pkg, reusable by the transmitter.
REQ-030 The 2-flop synchronizer SHALL be sub-module uart_sync (parameter RESET_VAL), instanced once.

Verification (CLKS_PER_BIT=16, DATA_BITS=8 unless noted)
REQ-031 Frame 0xA5, 8N1 -> data_out=8'hA5; data_valid pulses once, about 9.5 bit periods (+2 sync cycles) after the start edge; frame_err=0.
REQ-032 Low glitch of 5 clks on an idle line -> return to IDLE; no data_valid; busy high for at most 10 cycles.
REQ-033 0x3C sent with stop bit low, line then held low for 40 bit periods -> exactly one frame_err pulse, no data_valid; data_out keeps its previous value; a 0x55 sent afterwards is received correctly.
REQ-034 With UART_RX_PARITY_EN, even parity: 0x07 with parity bit 1 -> data_out=8'h07 with no error; parity bit 0 -> data_valid and parity_err pulse on the same cycle.
REQ-035 rst pulsed low at the 4th data bit of 0xFF, then 0x12 sent -> only 0x12 is reported; all outputs read 0 during reset.
REQ-036 DATA_BITS=5, CLKS_PER_BIT=4: back-to-back frames 0x1F, 0x00 with no idle gap -> two data_valid pulses with values 5'h1F and 5'h00.
